// File: rtl/pgm_rd_arbiter.sv
// pgm_rd_arbiter: shares one combinational program-memory read port between
// instruction fetch (port 0) and a debug/data reader (port 1). Round-robin
// arbitration with a bounded burst; registered single-cycle responses with
// error reporting for misaligned or out-of-range addresses.
module pgm_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 1024,
   parameter int BURST_LEN  = 4
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Req0,
   input  logic [ADDR_WIDTH-1:0] i_Addr0,
   output logic                  o_Ack0,
   output logic [DATA_WIDTH-1:0] o_RdData0,
   output logic                  o_Valid0,
   output logic                  o_Err0,
   input  logic                  i_Req1,
   input  logic [ADDR_WIDTH-1:0] i_Addr1,
   output logic                  o_Ack1,
   output logic [DATA_WIDTH-1:0] o_RdData1,
   output logic                  o_Valid1,
   output logic                  o_Err1,
   output logic [ADDR_WIDTH-1:0] o_MemAddr,
   input  logic [DATA_WIDTH-1:0] i_MemRdData
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0]         CNT_MAX   = CW'(BURST_LEN);
   localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_SIZE - 4);

   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

   port_e                  owner;
   port_e                  owner_nx;
   port_e                  gnt_port;
   port_e                  other;
   logic [CW-1:0]          beat_cnt;
   logic [CW-1:0]          cnt_nx;
   logic                   any_gnt;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic                   acc_err;

   assign other = (owner == PORT0) ? PORT1 : PORT0;

   // Arbitration: pick the granted port and the next owner/burst count
   always_comb begin
      any_gnt  = 1'b0;
      gnt_port = owner;
      owner_nx = owner;
      cnt_nx   = '0;
      if (i_Req0 && i_Req1) begin
         any_gnt = 1'b1;
         if (beat_cnt < CNT_MAX) begin
            gnt_port = owner;
            cnt_nx   = beat_cnt + CNT_ONE;
         end else begin
            gnt_port = other;
            owner_nx = other;
            cnt_nx   = CNT_ONE;
         end
      end else if (i_Req0 || i_Req1) begin
         any_gnt  = 1'b1;
         gnt_port = i_Req1 ? PORT1 : PORT0;
         if (gnt_port != owner) begin
            owner_nx = gnt_port;
            cnt_nx   = CNT_ONE;
         end else if (beat_cnt < CNT_MAX) begin
            cnt_nx = beat_cnt + CNT_ONE;
         end else begin
            cnt_nx = CNT_MAX;
         end
      end
   end

   assign o_Ack0   = any_gnt && (gnt_port == PORT0);
   assign o_Ack1   = any_gnt && (gnt_port == PORT1);
   assign sel_addr = (gnt_port == PORT1) ? i_Addr1 : i_Addr0;

   // Full-width compare so addresses near the top of the space never wrap into range
   assign acc_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
   assign o_MemAddr = (any_gnt && !acc_err) ? sel_addr : '0;

   // Arbitration state: last granted port and consecutive-beat count
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         owner    <= PORT0;
         beat_cnt <= '0;
      end else begin
         owner    <= owner_nx;
         beat_cnt <= cnt_nx;
      end
   end

   // Port 0 response register: one-cycle Valid pulse, data held between beats
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         o_Valid0  <= 1'b0;
         o_Err0    <= 1'b0;
         o_RdData0 <= '0;
      end else begin
         o_Valid0 <= o_Ack0;
         o_Err0   <= o_Ack0 && acc_err;
         if (o_Ack0) begin
            o_RdData0 <= acc_err ? '0 : i_MemRdData;
         end
      end
   end

   // Port 1 response register: one-cycle Valid pulse, data held between beats
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         o_Valid1  <= 1'b0;
         o_Err1    <= 1'b0;
         o_RdData1 <= '0;
      end else begin
         o_Valid1 <= o_Ack1;
         o_Err1   <= o_Ack1 && acc_err;
         if (o_Ack1) begin
            o_RdData1 <= acc_err ? '0 : i_MemRdData;
         end
      end
   end

endmodule

// File: tb/tb_pgm_rd_arbiter.sv
// tb_pgm_rd_arbiter: directed and randomized stimulus against a behavioural
// arbitration model; expected responses are queued per port and checked by
// an independent monitor whenever the DUT presents a response.
module tb_pgm_rd_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MS = 1024;
   localparam int BL = 4;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } rsp_t;

   logic          clk = 1'b0;
   logic          i_Reset;
   logic          i_Req0, i_Req1;
   logic [AW-1:0] i_Addr0, i_Addr1;
   logic          o_Ack0, o_Ack1;
   logic [DW-1:0] o_RdData0, o_RdData1;
   logic          o_Valid0, o_Valid1, o_Err0, o_Err1;
   logic [AW-1:0] o_MemAddr;
   logic [DW-1:0] i_MemRdData;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int            m_owner  = 0;
   int            m_streak = 0;
   rsp_t          q0[$];
   rsp_t          q1[$];
   logic [DW-1:0] last0 = '0;
   logic [DW-1:0] last1 = '0;

   always #5 clk = ~clk;

   pgm_rd_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MEM_SIZE  (MS),
      .BURST_LEN (BL)
   ) dut (
      .i_Clock    (clk),
      .i_Reset    (i_Reset),
      .i_Req0     (i_Req0),
      .i_Addr0    (i_Addr0),
      .o_Ack0     (o_Ack0),
      .o_RdData0  (o_RdData0),
      .o_Valid0   (o_Valid0),
      .o_Err0     (o_Err0),
      .i_Req1     (i_Req1),
      .i_Addr1    (i_Addr1),
      .o_Ack1     (o_Ack1),
      .o_RdData1  (o_RdData1),
      .o_Valid1   (o_Valid1),
      .o_Err1     (o_Err1),
      .o_MemAddr  (o_MemAddr),
      .i_MemRdData(i_MemRdData)
   );

   // Memory image: byte at address b holds b[7:0], words are big-endian
   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b, b + 8'd1, b + 8'd2, b + 8'd3};
   endfunction

   assign i_MemRdData = memf(o_MemAddr);

   function automatic logic is_err(input logic [AW-1:0] a);
      longint unsigned end_byte;
      end_byte = longint'(a) + 4;
      return (a % 4 != 0) || (end_byte > MS);
   endfunction

   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // Arbitration rules: returns 0/1 for the granted port, 2 for none
   task automatic arbitrate(input logic r0, input logic r1, output int g);
      if (!r0 && !r1) begin
         g = 2;
         m_streak = 0;
      end else if (r0 && r1) begin
         if (m_streak < BL) begin
            g = m_owner;
            m_streak++;
         end else begin
            g = 1 - m_owner;
            m_owner = g;
            m_streak = 1;
         end
      end else begin
         g = r1 ? 1 : 0;
         if (g != m_owner) begin
            m_owner = g;
            m_streak = 1;
         end else if (m_streak < BL) begin
            m_streak++;
         end
      end
   endtask

   // One bus cycle: drive, check combinational grant, queue expected response
   task automatic cycle(input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1, output int dg);
      int            g;
      logic [AW-1:0] ga;
      rsp_t          rs;
      @(negedge clk);
      i_Req0 = r0; i_Addr0 = a0;
      i_Req1 = r1; i_Addr1 = a1;
      #1;
      arbitrate(r0, r1, g);
      check("ack0", 64'(o_Ack0), 64'(g == 0));
      check("ack1", 64'(o_Ack1), 64'(g == 1));
      dg = o_Ack0 ? 0 : (o_Ack1 ? 1 : 2);
      if (g == 2) begin
         check("memaddr_idle", 64'(o_MemAddr), 64'd0);
      end else begin
         ga   = (g == 1) ? a1 : a0;
         rs.e = is_err(ga);
         rs.d = rs.e ? '0 : memf(ga);
         check("memaddr", 64'(o_MemAddr), rs.e ? 64'd0 : 64'(ga));
         if (g == 0) q0.push_back(rs);
         else        q1.push_back(rs);
      end
   endtask

   // Asserts reset (dropping in-flight responses), holds it with Req0 high, releases
   task automatic do_reset();
      i_Reset = 1'b0;
      i_Req0 = 1'b1; i_Addr0 = '0;
      i_Req1 = 1'b0; i_Addr1 = '0;
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      m_owner = 0; m_streak = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'({o_Valid0, o_Valid1}), 64'd0);
      check("rst_err",   64'({o_Err0, o_Err1}), 64'd0);
      check("rst_data",  64'({o_RdData0, o_RdData1}), 64'd0);
      i_Reset = 1'b1;
   endtask

   // Monitor: compares each port's response against the scoreboard queue
   task automatic mon_port(input int p);
      logic          v, e;
      logic [DW-1:0] d;
      rsp_t          rs;
      v = p ? o_Valid1 : o_Valid0;
      e = p ? o_Err1 : o_Err0;
      d = p ? o_RdData1 : o_RdData0;
      if (p == 0) begin
         check("valid0", 64'(v), 64'(q0.size() > 0));
         if (v && q0.size() > 0) begin
            rs = q0.pop_front();
            check("err0", 64'(e), 64'(rs.e));
            last0 = rs.d;
         end else begin
            check("err0_idle", 64'(e), 64'd0);
         end
         check("rdata0", 64'(d), 64'(last0));
      end else begin
         check("valid1", 64'(v), 64'(q1.size() > 0));
         if (v && q1.size() > 0) begin
            rs = q1.pop_front();
            check("err1", 64'(e), 64'(rs.e));
            last1 = rs.d;
         end else begin
            check("err1_idle", 64'(e), 64'd0);
         end
         check("rdata1", 64'(d), 64'(last1));
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mon_port(0);
         mon_port(1);
      end
   end

   function automatic logic [AW-1:0] pick_addr();
      int r;
      r = int'($urandom % 16);
      case (r)
         0: return AW'($urandom_range(0, MS - 1)) | 32'd1;
         1: return 32'h0000_0400;
         2: return 32'hFFFF_FFFC;
         3: return 32'h0000_03FC;
         4: return $urandom;
         default: return AW'($urandom_range(0, MS / 4 - 1)) << 2;
      endcase
   endfunction

   initial begin
      int dg;
      int exp_seq[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      int idle_seq[5] = '{0, 0, 0, 0, 1};
      logic          pend[2];
      logic [AW-1:0] pa[2];

      do_reset();
      cycle(1, 32'h0, 0, 32'h0, dg);
      check("first_after_rst", 64'(dg), 64'd0);

      // Back-to-back single-port beats
      cycle(1, 32'h0, 0, 32'h0, dg);
      cycle(1, 32'h4, 0, 32'h0, dg);
      cycle(1, 32'h8, 0, 32'h0, dg);
      cycle(0, 32'h0, 0, 32'h0, dg);
      cycle(0, 32'h0, 0, 32'h0, dg);

      // Contention with bounded burst
      for (int i = 0; i < 10; i++) begin
         cycle(1, 32'(i * 4), 1, 32'(64 + i * 4), dg);
         check("contend_grant", 64'(dg), 64'(exp_seq[i]));
      end
      cycle(0, 32'h0, 0, 32'h0, dg);

      // Error and range boundaries on port 1
      cycle(0, 32'h0, 1, 32'h0000_0002, dg);
      cycle(0, 32'h0, 1, 32'h0000_03FC, dg);
      cycle(0, 32'h0, 1, 32'h0000_0400, dg);
      cycle(0, 32'h0, 1, 32'hFFFF_FFFC, dg);
      cycle(0, 32'h0, 0, 32'h0, dg);

      // Idle resets the burst count
      cycle(1, 32'h10, 0, 32'h0, dg);
      cycle(1, 32'h14, 0, 32'h0, dg);
      cycle(0, 32'h0, 0, 32'h0, dg);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 32'(32 + i * 4), 1, 32'(128 + i * 4), dg);
         check("idle_grant", 64'(dg), 64'(idle_seq[i]));
      end
      cycle(0, 32'h0, 0, 32'h0, dg);

      // Reset while a port 1 response is in flight
      cycle(0, 32'h0, 1, 32'h20, dg);
      check("pre_rst_ack1", 64'(dg), 64'd1);
      do_reset();
      cycle(1, 32'h40, 1, 32'h44, dg);
      check("post_rst_grant", 64'(dg), 64'd0);

      // Randomized traffic; requesters hold Req/Addr until acknowledged
      pend[0] = 1'b0; pend[1] = 1'b0;
      pa[0] = '0; pa[1] = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom % 3 != 0)) begin
               pend[p] = 1'b1;
               pa[p]   = pick_addr();
            end
         end
         cycle(pend[0], pa[0], pend[1], pa[1], dg);
         if (dg < 2) pend[dg] = 1'b0;
      end

      cycle(0, 32'h0, 0, 32'h0, dg);
      cycle(0, 32'h0, 0, 32'h0, dg);
      @(posedge clk);
      #2;
      check("q_drained", 64'(q0.size() + q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
